// File: rtl/mlp_fixed_pkg.sv
// Shared definitions for the sequential fixed-point perceptron network:
// default word geometry, the 1.0 constant, the FSM state type and the
// sign-magnitude / two's-complement conversion helpers.
// The optional pre-activation output is enabled with macro MLP_SUM_OUT_EN.
package mlp_fixed_pkg;

    localparam int TAM_DEF  = 16;
    localparam int FRAC_DEF = 12;
    localparam logic [TAM_DEF-1:0] ONE_FXP = TAM_DEF'(1) << FRAC_DEF;

    // Helpers work on a wide container; callers pass the real word width in w.
    localparam int MAXW = 64;

    typedef enum logic [1:0] {IDLE, HID, OUT, DONE} state_t;

    // Sign-magnitude to two's complement; a negative zero comes out as 0.
    function automatic logic signed [MAXW-1:0] sm2tc(input logic [MAXW-1:0] sm, input int w);
        logic [MAXW-1:0] mag;
        mag = sm & ((MAXW'(1) << (w - 1)) - MAXW'(1));
        return sm[w-1] ? -$signed(mag) : $signed(mag);
    endfunction

    // Magnitude of a two's-complement value, clipped to what w-1 bits can hold.
    function automatic logic [MAXW-1:0] sat(input logic signed [MAXW-1:0] v, input int w);
        logic [MAXW-1:0] mag;
        logic [MAXW-1:0] lim;
        lim = (MAXW'(1) << (w - 1)) - MAXW'(1);
        mag = v[MAXW-1] ? $unsigned(-v) : $unsigned(v);
        return (mag > lim) ? lim : mag;
    endfunction

    // Two's complement to saturated sign-magnitude; zero is always +0.
    function automatic logic [MAXW-1:0] tc2sm(input logic signed [MAXW-1:0] v, input int w);
        logic [MAXW-1:0] mag;
        mag = sat(v, w);
        return (v[MAXW-1] && (mag != '0)) ? (mag | (MAXW'(1) << (w - 1))) : mag;
    endfunction

endpackage

// File: rtl/mlp2_fixed_seq_if.sv
// Bus bundle for mlp2_fixed_seq: weight load port, sample input stream and
// result output stream. With MLP_SUM_OUT_EN the bundle also carries out_sum.
interface mlp2_fixed_seq_if
    import mlp_fixed_pkg::*;
#(
    parameter int TAM     = TAM_DEF,
    parameter int NUM_IN  = 2,
    parameter int NUM_HID = 2,
    parameter int AW      = 4
);
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [TAM-1:0]          wr_data;
    logic                    wr_err;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_IN*TAM-1:0]   in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [TAM-1:0]          out_data;
    logic [NUM_HID-1:0]      out_hid;
`ifdef MLP_SUM_OUT_EN
    logic [TAM-1:0]          out_sum;

    modport master (output wr_en, wr_addr, wr_data, in_valid, in_data, out_ready,
                    input  wr_err, in_ready, out_valid, out_data, out_hid, out_sum);
    modport slave  (input  wr_en, wr_addr, wr_data, in_valid, in_data, out_ready,
                    output wr_err, in_ready, out_valid, out_data, out_hid, out_sum);
`else
    modport master (output wr_en, wr_addr, wr_data, in_valid, in_data, out_ready,
                    input  wr_err, in_ready, out_valid, out_data, out_hid);
    modport slave  (input  wr_en, wr_addr, wr_data, in_valid, in_data, out_ready,
                    output wr_err, in_ready, out_valid, out_data, out_hid);
`endif
endinterface

// File: rtl/fxp_sm_mac.sv
// Single-cycle sign-magnitude multiply-accumulate shared by both layers.
// clr starts a new sum with the current product instead of adding to acc.
// acc_next is the value acc takes at the coming edge, so the caller can
// threshold a neuron in the same cycle as its last term.
module fxp_sm_mac
    import mlp_fixed_pkg::*;
#(
    parameter int TAM   = TAM_DEF,
    parameter int ACC_W = 2*TAM_DEF + 2
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic [TAM-1:0]          a,
    input  logic [TAM-1:0]          b,
    output logic signed [ACC_W-1:0] acc_next
);
    logic signed [2*TAM-1:0] a_tc;
    logic signed [2*TAM-1:0] b_tc;
    logic signed [2*TAM-1:0] prod;
    logic signed [ACC_W-1:0] acc;

    // Convert both operands, form the full-width product and the next sum.
    always_comb begin
        a_tc     = (2*TAM)'(sm2tc(MAXW'(a), TAM));
        b_tc     = (2*TAM)'(sm2tc(MAXW'(b), TAM));
        prod     = a_tc * b_tc;
        acc_next = clr ? ACC_W'(prod) : acc + ACC_W'(prod);
    end

    // Accumulator register, advanced only on evaluation cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end
endmodule

// File: rtl/mlp2_fixed_seq.sv
// Sequential two-layer step-activation perceptron on sign-magnitude fixed
// point. One MAC walks the weight file in address order: each hidden neuron
// takes a bias cycle plus NUM_IN input cycles, then the output neuron takes a
// bias cycle plus NUM_HID cycles gated by the hidden activations.
// Optional feature macro: MLP_SUM_OUT_EN adds out_sum (output pre-activation).
module mlp2_fixed_seq
    import mlp_fixed_pkg::*;
#(
    parameter int TAM     = TAM_DEF,
    parameter int FRAC    = FRAC_DEF,
    parameter int NUM_IN  = 2,
    parameter int NUM_HID = 2,
    parameter int NW      = NUM_HID*(NUM_IN+1) + NUM_HID + 1,
    parameter int AW      = $clog2(NW)
)(
    input  logic            clk,
    input  logic            rst_n,
    mlp2_fixed_seq_if.slave bus
);
    localparam int ACC_W = 2*TAM + $clog2(NUM_IN + 2);
    localparam int TW    = $clog2(((NUM_IN > NUM_HID) ? NUM_IN : NUM_HID) + 1);
    localparam int HW    = $clog2(NUM_HID + 1);
    localparam logic [TAM-1:0] ONE = (TAM == TAM_DEF && FRAC == FRAC_DEF) ?
                                     TAM'(ONE_FXP) : (TAM'(1) << FRAC);

    state_t                  state;
    logic [TAM-1:0]          weights [NW];
    logic [NUM_IN*TAM-1:0]   x_reg;
    logic [NUM_HID-1:0]      h;
    logic [AW-1:0]           waddr;
    logic [TW-1:0]           term;
    logic [HW-1:0]           nrn;
    logic                    mac_en;
    logic                    mac_clr;
    logic [TAM-1:0]          op_b;
    logic signed [ACC_W-1:0] acc_next;
    logic                    acc_pos;
    logic                    write_ok;

    // MAC operand selection: term 0 is the bias (times 1.0), later terms take
    // an input sample in HID or a 0/1.0 hidden activation in OUT.
    always_comb begin
        mac_en  = (state == HID) || (state == OUT);
        mac_clr = (term == '0);
        op_b    = ONE;
        if (state == HID) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (int'(term) == i + 1) op_b = x_reg[i*TAM +: TAM];
            end
        end else begin
            for (int k = 0; k < NUM_HID; k++) begin
                if (int'(term) == k + 1) op_b = h[k] ? ONE : '0;
            end
        end
        acc_pos  = !acc_next[ACC_W-1] && (acc_next != '0);
        write_ok = bus.wr_en && (state == IDLE) && (int'(bus.wr_addr) < NW);
    end

    fxp_sm_mac #(.TAM(TAM), .ACC_W(ACC_W)) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (mac_en),
        .clr      (mac_clr),
        .a        (weights[waddr]),
        .b        (op_b),
        .acc_next (acc_next)
    );

    // Weight file writes, only while idle; dropped writes raise wr_err for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) weights[i] <= '0;
            bus.wr_err <= 1'b0;
        end else begin
            if (write_ok) weights[bus.wr_addr] <= bus.wr_data;
            bus.wr_err <= bus.wr_en && !write_ok;
        end
    end

    // Evaluation sequencer with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            x_reg         <= '0;
            h             <= '0;
            waddr         <= '0;
            term          <= '0;
            nrn           <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_hid   <= '0;
`ifdef MLP_SUM_OUT_EN
            bus.out_sum   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        x_reg        <= bus.in_data;
                        waddr        <= '0;
                        term         <= '0;
                        nrn          <= '0;
                        bus.in_ready <= 1'b0;
                        state        <= HID;
                    end else begin
                        bus.in_ready <= 1'b1;
                    end
                end
                HID: begin
                    waddr <= waddr + 1'b1;
                    if (int'(term) == NUM_IN) begin
                        term <= '0;
                        for (int j = 0; j < NUM_HID; j++) begin
                            if (int'(nrn) == j) h[j] <= acc_pos;
                        end
                        if (int'(nrn) == NUM_HID - 1) begin
                            nrn   <= '0;
                            state <= OUT;
                        end else begin
                            nrn <= nrn + 1'b1;
                        end
                    end else begin
                        term <= term + 1'b1;
                    end
                end
                OUT: begin
                    if (int'(term) == NUM_HID) begin
                        term          <= '0;
                        waddr         <= '0;
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= acc_pos ? ONE : '0;
                        bus.out_hid   <= h;
`ifdef MLP_SUM_OUT_EN
                        bus.out_sum   <= TAM'(tc2sm(MAXW'(acc_next >>> FRAC), TAM));
`endif
                        state         <= DONE;
                    end else begin
                        term  <= term + 1'b1;
                        waddr <= waddr + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mlp2_fixed_seq.sv
// Self-checking bench for mlp2_fixed_seq. Expected results come from an
// integer model of the network evaluated straight from the weight map and
// the step rule. With MLP_SUM_OUT_EN the pre-activation output is checked too.
module tb_mlp2_fixed_seq;
    import mlp_fixed_pkg::*;

    localparam logic [15:0] P_ONE  = ONE_FXP;
    localparam logic [15:0] N_ONE  = 16'h9000;
    localparam logic [15:0] P_HALF = 16'h0800;
    localparam logic [15:0] N_HALF = 16'h8800;
    localparam logic [15:0] N_ZERO = 16'h8000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic [15:0] w_model [9];

    mlp2_fixed_seq_if #(.TAM(16), .NUM_IN(2), .NUM_HID(2), .AW(4)) bus ();

    mlp2_fixed_seq #(.TAM(16), .FRAC(12), .NUM_IN(2), .NUM_HID(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic longint smv(input logic [15:0] v);
        return v[15] ? -longint'(v[14:0]) : longint'(v[14:0]);
    endfunction

    // Network reference: hidden sums at 2^24 scale, output sum at 2^12 scale.
    task automatic model(input logic [15:0] x0, input logic [15:0] x1,
                         output logic [15:0] e_data, output logic [1:0] e_hid,
                         output logic [15:0] e_sum);
        longint xs [2];
        longint a;
        longint s;
        longint mag;
        xs[0] = smv(x0);
        xs[1] = smv(x1);
        for (int j = 0; j < 2; j++) begin
            a = smv(w_model[j*3]) * 4096;
            for (int i = 0; i < 2; i++) a += smv(w_model[j*3 + 1 + i]) * xs[i];
            e_hid[j] = (a > 0);
        end
        s = smv(w_model[6]);
        for (int k = 0; k < 2; k++) if (e_hid[k]) s += smv(w_model[7 + k]);
        e_data = (s > 0) ? P_ONE : 16'h0000;
        mag = (s < 0) ? -s : s;
        if (mag > 32767) mag = 32767;
        e_sum = {(s < 0), mag[14:0]};
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_weight(input logic [3:0] addr, input logic [15:0] data, input logic exp_err);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en = 1'b0;
        if (!exp_err) w_model[addr] = data;
        else check_output("wr_err pulse", 32'(bus.wr_err), 32'(1'b1));
    endtask

    task automatic load_weights(input logic [15:0] ws [9]);
        for (int i = 0; i < 9; i++) write_weight(4'(i), ws[i], 1'b0);
        check_output("wr_err after load", 32'(bus.wr_err), 32'(1'b0));
    endtask

    // Presents one sample and returns just after the accepting edge.
    task automatic apply_stimulus(input logic [15:0] x0, input logic [15:0] x1);
        int n = 0;
        while (!bus.in_ready && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) check_output("in_ready timeout", 32'(bus.in_ready), 32'(1'b1));
        bus.in_valid = 1'b1;
        bus.in_data  = {x1, x0};
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [15:0] x0, input logic [15:0] x1,
                               input int start_cyc);
        logic [15:0] e_data;
        logic [1:0]  e_hid;
        logic [15:0] e_sum;
        int cyc = start_cyc;
        model(x0, x1, e_data, e_hid, e_sum);
        while (!bus.out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check_output({tag, " latency"}, 32'(cyc), 32'd9);
        check_output({tag, " out_data"}, 32'(bus.out_data), 32'(e_data));
        check_output({tag, " out_hid"}, 32'(bus.out_hid), 32'(e_hid));
        check_output({tag, " in_ready"}, 32'(bus.in_ready), 32'(1'b0));
`ifdef MLP_SUM_OUT_EN
        check_output({tag, " out_sum"}, 32'(bus.out_sum), 32'(e_sum));
`endif
    endtask

    task automatic drain(input string tag);
        tick();
        check_output({tag, " out_valid drop"}, 32'(bus.out_valid), 32'(1'b0));
        check_output({tag, " in_ready back"}, 32'(bus.in_ready), 32'(1'b1));
    endtask

    task automatic run_sample(input string tag, input logic [15:0] x0, input logic [15:0] x1);
        apply_stimulus(x0, x1);
        wait_result(tag, x0, x1, 0);
        drain(tag);
    endtask

    function automatic logic [15:0] rand_sm();
        logic [14:0] mag;
        mag = ($urandom_range(0, 7) == 0) ? 15'd0 : 15'($urandom_range(0, 16'h2000));
        return {1'($urandom_range(0, 1)), mag};
    endfunction

    initial begin
        logic [15:0] xor_w [9];
        logic [15:0] rnd_w [9];
        logic [15:0] e_data;
        logic [1:0]  e_hid;
        logic [15:0] e_sum;
        int seen;

        xor_w = '{N_HALF, P_ONE, N_ONE, N_HALF, N_ONE, P_ONE, N_HALF, P_ONE, P_ONE};
        for (int i = 0; i < 9; i++) w_model[i] = 16'h0000;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;

        // Reset state
        tick(); tick();
        check_output("reset in_ready", 32'(bus.in_ready), 32'(1'b0));
        check_output("reset out_valid", 32'(bus.out_valid), 32'(1'b0));
        check_output("reset out_data", 32'(bus.out_data), 32'h0);
        check_output("reset out_hid", 32'(bus.out_hid), 32'h0);
        check_output("reset wr_err", 32'(bus.wr_err), 32'(1'b0));
        #3 rst_n = 1'b1;
        tick();
        check_output("idle in_ready", 32'(bus.in_ready), 32'(1'b1));
        run_sample("zero weights", P_ONE, P_ONE);

        // XOR truth table
        load_weights(xor_w);
        run_sample("xor 00", 16'h0000, 16'h0000);
        run_sample("xor 10", P_ONE, 16'h0000);
        run_sample("xor 01", 16'h0000, P_ONE);
        run_sample("xor 11", P_ONE, P_ONE);

        // Step threshold: exactly zero stays off, just above zero fires
        write_weight(4'd0, N_HALF, 1'b0);
        write_weight(4'd1, P_HALF, 1'b0);
        write_weight(4'd2, 16'h0000, 1'b0);
        model(P_ONE, 16'h0000, e_data, e_hid, e_sum);
        check_output("model boundary h0", 32'(e_hid[0]), 32'(1'b0));
        run_sample("boundary zero", P_ONE, 16'h0000);
        write_weight(4'd0, 16'h87FF, 1'b0);
        run_sample("boundary above", P_ONE, 16'h0000);

        // Backpressure
        load_weights(xor_w);
        bus.out_ready = 1'b0;
        apply_stimulus(P_ONE, 16'h0000);
        wait_result("bp", P_ONE, 16'h0000, 0);
        model(P_ONE, 16'h0000, e_data, e_hid, e_sum);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_output("bp out_valid", 32'(bus.out_valid), 32'(1'b1));
            check_output("bp out_data", 32'(bus.out_data), 32'(e_data));
            check_output("bp out_hid", 32'(bus.out_hid), 32'(e_hid));
            check_output("bp in_ready", 32'(bus.in_ready), 32'(1'b0));
        end
        bus.out_ready = 1'b1;
        drain("bp release");

        // Dropped writes: during evaluation and out of range
        apply_stimulus(16'h0000, P_ONE);
        write_weight(4'd0, 16'h7FFF, 1'b1);
        tick();
        check_output("wr_err one cycle", 32'(bus.wr_err), 32'(1'b0));
        wait_result("busy write", 16'h0000, P_ONE, 2);
        drain("busy write");
        write_weight(4'd9, P_ONE, 1'b1);
        tick();
        check_output("wr_err range clear", 32'(bus.wr_err), 32'(1'b0));
        run_sample("readback 10", P_ONE, 16'h0000);
        run_sample("readback 01", 16'h0000, P_ONE);

        // Reset in the middle of an evaluation
        apply_stimulus(P_ONE, 16'h0000);
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check_output("midreset out_valid", 32'(bus.out_valid), 32'(1'b0));
        check_output("midreset in_ready", 32'(bus.in_ready), 32'(1'b0));
        for (int i = 0; i < 9; i++) w_model[i] = 16'h0000;
        tick();
        #3 rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check_output("midreset no stale valid", 32'(seen), 32'd0);
        run_sample("post reset", P_ONE, 16'h0000);

        // Negative zero inputs behave as 0.0
        load_weights(xor_w);
        run_sample("negzero both", N_ZERO, N_ZERO);
        run_sample("negzero x1", P_ONE, N_ZERO);
        run_sample("negzero x0", N_ZERO, P_ONE);

        // Random weights and samples
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 9; i++) rnd_w[i] = rand_sm();
            load_weights(rnd_w);
            run_sample($sformatf("random %0d", r), rand_sm(), rand_sm());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
